databus_arbiter: RTL and testbench



---
 rtl/databus_arbiter_pkg.sv | 17 +
 rtl/databus_arbiter_if.sv | 22 ++
 rtl/databus_arbiter_rr_pick.sv | 33 +++
 rtl/databus_arbiter.sv | 98 +++++++++
 tb/tb_databus_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/databus_arbiter_pkg.sv
// Shared constants and state encoding for the databus arbiter and its neighbours.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_MAX_HOLD    = 8;
    localparam int DEF_TURN_CYCLES = 1;

    // Databus width, shared with the input logic and the register file.
    localparam int DATA_W = 10;

endpackage

// File: rtl/databus_arbiter_if.sv
// Request/enable bundle between the bus drivers and the databus arbiter.
interface databus_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);
    logic [NUM_REQ-1:0]         Req;
    logic [NUM_REQ-1:0]         Bus_Enable;
    logic [$clog2(NUM_REQ)-1:0] Grant_Id;
    logic                       Bus_Busy;
    logic                       Preempt;

    modport master (
        input  Req,
        output Bus_Enable, Grant_Id, Bus_Busy, Preempt
    );

    modport slave (
        output Req,
        input  Bus_Enable, Grant_Id, Bus_Busy, Preempt
    );
endinterface

// File: rtl/databus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    localparam int W       = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [W-1:0]       ptr,
    output logic [W-1:0]       winner,
    output logic               any_req
);
    localparam int IW = W + 1;

    logic [IW-1:0] idx;

    // Wrap by explicit compare so non-power-of-two NUM_REQ never yields an
    // index past NUM_REQ-1.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + IW'(i);
            if (idx >= IW'(NUM_REQ))
                idx = idx - IW'(NUM_REQ);
            if (!any_req && req[idx[W-1:0]]) begin
                winner  = idx[W-1:0];
                any_req = 1'b1;
            end
        end
    end
endmodule

// File: rtl/databus_arbiter.sv
// Round-robin owner of the shared tri-state databus with bounded hold and a
// post-release turnaround gap; all outputs come straight from flops.
module databus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int MAX_HOLD    = DEF_MAX_HOLD,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
    input  logic              CLK_50MHz,
    input  logic              Rst_n,
    databus_arbiter_if.master bus
);
    localparam int W  = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_GRANT = GRANT;
    localparam logic [1:0] S_TURN  = TURN;

    localparam logic [W-1:0]       LAST_ID   = W'(NUM_REQ - 1);
    localparam logic [HW-1:0]      HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [1:0]         TURN_LAST = 2'(TURN_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);

    logic [1:0]         state;
    logic [HW-1:0]      hold_cnt;
    logic [1:0]         turn_cnt;
    logic [W-1:0]       ptr;
    logic [NUM_REQ-1:0] en_q;
    logic [W-1:0]       gid_q;
    logic               busy_q;
    logic               pre_q;

    logic [W-1:0] win;
    logic         any_req;
    logic         owner_req;
    logic         others_req;
    logic         arb_go;
    logic         release_go;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (bus.Req),
        .ptr     (ptr),
        .winner  (win),
        .any_req (any_req)
    );

    assign owner_req  = bus.Req[gid_q];
    assign others_req = |(bus.Req & ~en_q);
    // IDLE and the final TURN cycle both arbitrate, so a waiter sees no extra idle cycle.
    assign arb_go     = (state != S_GRANT) && ((state != S_TURN) || (turn_cnt == TURN_LAST));
    assign release_go = !owner_req || ((hold_cnt == HOLD_LAST) && others_req);

    always_ff @(posedge CLK_50MHz) begin
        if (!Rst_n) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            turn_cnt <= '0;
            ptr      <= '0;
            en_q     <= '0;
            gid_q    <= '0;
            busy_q   <= 1'b0;
            pre_q    <= 1'b0;
        end else begin
            pre_q <= 1'b0;
            if (arb_go) begin
                if (any_req) begin
                    en_q     <= ONE << win;
                    gid_q    <= win;
                    busy_q   <= 1'b1;
                    hold_cnt <= '0;
                    state    <= S_GRANT;
                end else begin
                    state    <= S_IDLE;
                end
            end else if (state == S_GRANT) begin
                if (release_go) begin
                    en_q     <= '0;
                    busy_q   <= 1'b0;
                    pre_q    <= owner_req;
                    ptr      <= (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;
                    turn_cnt <= '0;
                    state    <= (TURN_CYCLES == 0) ? S_IDLE : S_TURN;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end else begin
                turn_cnt <= turn_cnt + 1'b1;
            end
        end
    end

    assign bus.Bus_Enable = en_q;
    assign bus.Grant_Id   = gid_q;
    assign bus.Bus_Busy   = busy_q;
    assign bus.Preempt    = pre_q;
endmodule

// File: tb/tb_databus_arbiter.sv
// Directed bench for databus_arbiter (NUM_REQ=4, MAX_HOLD=8, TURN_CYCLES=1)
// with a per-cycle invariant monitor.
module tb_databus_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #10 clk = ~clk;

    databus_arbiter_if #(.NUM_REQ(4)) bus ();

    databus_arbiter #(.NUM_REQ(4), .MAX_HOLD(8), .TURN_CYCLES(1)) dut (
        .CLK_50MHz (clk),
        .Rst_n     (rst_n),
        .bus       (bus)
    );

    // Invariants: at most one enable, Busy mirrors enables, gap between owners.
    logic [3:0] last_en = '0;
    int         zero_run = 0;
    always @(negedge clk) begin
        checks++;
        if ($countones(bus.Bus_Enable) > 1) begin
            errors++;
            $display("FAIL inv_onehot got %b exp <=1 bit set", bus.Bus_Enable);
        end
        checks++;
        if (bus.Bus_Busy !== (|bus.Bus_Enable)) begin
            errors++;
            $display("FAIL inv_busy got %b exp %b", bus.Bus_Busy, |bus.Bus_Enable);
        end
        if (bus.Bus_Enable != 4'b0) begin
            if (last_en != 4'b0 && bus.Bus_Enable != last_en) begin
                checks++;
                if (zero_run < 1) begin
                    errors++;
                    $display("FAIL inv_gap got %0d idle cycles exp >=1 (%b -> %b)",
                             zero_run, last_en, bus.Bus_Enable);
                end
            end
            last_en  = bus.Bus_Enable;
            zero_run = 0;
        end else begin
            zero_run++;
        end
        if (!rst_n) last_en = '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_reset();
        bus.Req = 4'b0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.Req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.Bus_Enable !== 4'b0 || bus.Bus_Busy !== 1'b0 || bus.Preempt !== 1'b0 ||
                bus.Grant_Id !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold got en=%b busy=%b pre=%b id=%0d exp all 0",
                         bus.Bus_Enable, bus.Bus_Busy, bus.Preempt, bus.Grant_Id);
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.Bus_Enable !== 4'b0001 || bus.Grant_Id !== 2'd0 || bus.Bus_Busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant got en=%b id=%0d busy=%b exp 0001/0/1",
                     bus.Bus_Enable, bus.Grant_Id, bus.Bus_Busy);
        end
    endtask

    task automatic test_single_owner();
        quiet_reset();
        bus.Req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.Bus_Enable !== 4'b0100 || bus.Bus_Busy !== 1'b1 || bus.Preempt !== 1'b0 ||
                bus.Grant_Id !== 2'd2) begin
                errors++;
                $display("FAIL single_hold[%0d] got en=%b busy=%b pre=%b id=%0d exp 0100/1/0/2",
                         i, bus.Bus_Enable, bus.Bus_Busy, bus.Preempt, bus.Grant_Id);
            end
        end
        bus.Req = 4'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.Bus_Enable !== 4'b0 || bus.Bus_Busy !== 1'b0 || bus.Preempt !== 1'b0) begin
                errors++;
                $display("FAIL single_release[%0d] got en=%b busy=%b pre=%b exp 0000/0/0",
                         i, bus.Bus_Enable, bus.Bus_Busy, bus.Preempt);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_en;
        logic       exp_pre;
        int         owner;
        int         slot;
        quiet_reset();
        bus.Req = 4'b1111;
        // 8 owned cycles then one idle (preempt) cycle per owner
        for (int t = 0; t < 45; t++) begin
            tick();
            slot    = t % 9;
            owner   = (t / 9) % 4;
            exp_en  = (slot < 8) ? (4'b0001 << owner) : 4'b0000;
            exp_pre = (slot == 8);
            checks++;
            if (bus.Bus_Enable !== exp_en || bus.Preempt !== exp_pre ||
                (slot < 8 && bus.Grant_Id !== 2'(owner))) begin
                errors++;
                $display("FAIL rr_cycle[%0d] got en=%b pre=%b id=%0d exp en=%b pre=%b id=%0d",
                         t, bus.Bus_Enable, bus.Preempt, bus.Grant_Id, exp_en, exp_pre, owner);
            end
        end
        bus.Req = 4'b0;
    endtask

    task automatic test_lone_owner();
        quiet_reset();
        bus.Req = 4'b0100;
        for (int i = 0; i < 21; i++) begin
            tick();
            checks++;
            if (bus.Bus_Enable !== 4'b0100 || bus.Preempt !== 1'b0) begin
                errors++;
                $display("FAIL lone_owner[%0d] got en=%b pre=%b exp 0100/0",
                         i, bus.Bus_Enable, bus.Preempt);
            end
        end
        bus.Req = 4'b0;
    endtask

    task automatic test_pointer_order();
        quiet_reset();
        bus.Req = 4'b0010;
        tick();
        tick();
        checks++;
        if (bus.Bus_Enable !== 4'b0010) begin
            errors++;
            $display("FAIL ptr_owner1 got en=%b exp 0010", bus.Bus_Enable);
        end
        bus.Req = 4'b1001;
        tick();
        checks++;
        if (bus.Bus_Enable !== 4'b0000 || bus.Preempt !== 1'b0) begin
            errors++;
            $display("FAIL ptr_gap got en=%b pre=%b exp 0000/0", bus.Bus_Enable, bus.Preempt);
        end
        tick();
        checks++;
        if (bus.Bus_Enable !== 4'b1000 || bus.Grant_Id !== 2'd3) begin
            errors++;
            $display("FAIL ptr_owner3 got en=%b id=%0d exp 1000/3", bus.Bus_Enable, bus.Grant_Id);
        end
        tick();
        bus.Req = 4'b0001;
        tick();
        tick();
        checks++;
        if (bus.Bus_Enable !== 4'b0001 || bus.Grant_Id !== 2'd0) begin
            errors++;
            $display("FAIL ptr_owner0 got en=%b id=%0d exp 0001/0", bus.Bus_Enable, bus.Grant_Id);
        end
        bus.Req = 4'b0;
    endtask

    task automatic test_reset_midflight();
        quiet_reset();
        // owner 1 releases (pointer -> 2), owner 2 granted, then reset mid-GRANT
        bus.Req = 4'b0010;
        tick();
        bus.Req = 4'b0100;
        tick();
        tick();
        checks++;
        if (bus.Bus_Enable !== 4'b0100) begin
            errors++;
            $display("FAIL midgrant_setup got en=%b exp 0100", bus.Bus_Enable);
        end
        rst_n   = 1'b0;
        bus.Req = 4'b1111;
        tick();
        checks++;
        if (bus.Bus_Enable !== 4'b0 || bus.Grant_Id !== 2'd0 || bus.Bus_Busy !== 1'b0 ||
            bus.Preempt !== 1'b0) begin
            errors++;
            $display("FAIL midgrant_reset got en=%b id=%0d busy=%b pre=%b exp all 0",
                     bus.Bus_Enable, bus.Grant_Id, bus.Bus_Busy, bus.Preempt);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.Bus_Enable !== 4'b0001 || bus.Grant_Id !== 2'd0) begin
            errors++;
            $display("FAIL midgrant_ptr got en=%b id=%0d exp 0001/0", bus.Bus_Enable, bus.Grant_Id);
        end
        // owner 0 drops -> TURN, then reset inside the turnaround
        bus.Req = 4'b0;
        tick();
        rst_n   = 1'b0;
        bus.Req = 4'b0010;
        tick();
        checks++;
        if (bus.Bus_Enable !== 4'b0 || bus.Bus_Busy !== 1'b0 || bus.Preempt !== 1'b0) begin
            errors++;
            $display("FAIL midturn_reset got en=%b busy=%b pre=%b exp all 0",
                     bus.Bus_Enable, bus.Bus_Busy, bus.Preempt);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.Bus_Enable !== 4'b0010 || bus.Grant_Id !== 2'd1) begin
            errors++;
            $display("FAIL midturn_regrant got en=%b id=%0d exp 0010/1", bus.Bus_Enable, bus.Grant_Id);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            bus.Req = 4'($urandom);
            rst_n   = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n   = 1'b1;
        bus.Req = 4'b0;
        tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.Req = 4'b0;
        test_reset();
        test_single_owner();
        test_round_robin();
        test_lone_owner();
        test_pointer_order();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
